// File: rtl/demux_dispatch_pkg.sv
// Shared network definitions: port indices, packet field defaults and table types
// used by the demux dispatch stage.
package demux_dispatch_pkg;

  localparam int unsigned NUM_PORTS = 7;

  localparam int unsigned LOCAL = 0;
  localparam int unsigned YNEG  = 1;
  localparam int unsigned YPOS  = 2;
  localparam int unsigned XPOS  = 3;
  localparam int unsigned XNEG  = 4;
  localparam int unsigned ZPOS  = 5;
  localparam int unsigned ZNEG  = 6;

  localparam int unsigned DATA_WIDTH_DEF        = 256;
  localparam int unsigned MULTICAST_BIT_POS_DEF = 253;
  localparam int unsigned DST_PACKET_ID_POS_DEF = 186;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef logic [NUM_PORTS-1:0] port_mask_t;

  typedef enum logic {
    TBL_ROUTE = 1'b0,
    TBL_MCAST = 1'b1
  } tbl_sel_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/demux_dispatch_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on dout while not empty.
module demux_dispatch_fifo #(
  parameter int unsigned FIFO_depth = 4,
  parameter int unsigned FIFO_width = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FIFO_width-1:0] din,
  output logic [FIFO_width-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PW = (FIFO_depth > 1) ? $clog2(FIFO_depth) : 1;
  localparam int unsigned CW = $clog2(FIFO_depth + 1);

  logic [FIFO_width-1:0] mem [FIFO_depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_depth - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (count == CW'(FIFO_depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// Input FIFO -> table lookup (LK) -> per-port dispatch (DP) with registered outputs.
// Multicast packets are delivered port by port as downstream space frees up.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned DataWidth              = DATA_WIDTH_DEF,
  parameter int unsigned MulticastBitPos        = MULTICAST_BIT_POS_DEF,
  parameter int unsigned DstPacketIDPos         = DST_PACKET_ID_POS_DEF,
  parameter int unsigned InterSwitchBufferDepth = 4,
  parameter int unsigned TableSize              = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DataWidth-1:0]             in,
  input  logic                             in_pipeline_stall,
  output logic                             in_avail,
  output logic [NUM_PORTS*DataWidth-1:0]   out_data,
  output logic [NUM_PORTS-1:0]             out_pipeline_stall,
  input  logic [NUM_PORTS-1:0]             out_avail,
  input  logic                             cfg_we,
  input  logic                             cfg_sel,
  input  logic [7:0]                       cfg_addr,
  input  logic [NUM_PORTS-1:0]             cfg_data,
  output logic [15:0]                      drop_cnt
);

  localparam int unsigned AW = $clog2(TableSize);

  port_mask_t route_tbl [TableSize];
  port_mask_t mcast_tbl [TableSize];

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DataWidth-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 lk_valid;
  logic [DataWidth-1:0] pkt_lk;
  port_mask_t           mask_lk;

  logic                 dp_valid;
  logic [DataWidth-1:0] pkt_dp;
  port_mask_t           pending;

  port_mask_t           grant;
  logic                 dp_done;
  logic                 lk_adv;
  logic [AW-1:0]        rd_idx;
  tbl_sel_e             rd_sel;
  port_mask_t           rd_mask;

  demux_dispatch_fifo #(
    .FIFO_depth (InterSwitchBufferDepth),
    .FIFO_width (DataWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_push = ~in_pipeline_stall & in[DataWidth-1];
  assign in_avail  = ~fifo_full;

  always_comb begin
    grant    = dp_valid ? (pending & out_avail) : '0;
    dp_done  = ((pending & ~grant) == '0);
    lk_adv   = lk_valid & (~dp_valid | dp_done);
    fifo_pop = ~fifo_empty & (~lk_valid | lk_adv);
    rd_idx   = fifo_dout[DstPacketIDPos +: AW];
    rd_sel   = fifo_dout[MulticastBitPos] ? TBL_MCAST : TBL_ROUTE;
    rd_mask  = (rd_sel == TBL_MCAST) ? mcast_tbl[rd_idx] : route_tbl[rd_idx];
    // A same-cycle write to the entry being looked up wins over the stored value
    if (cfg_we && (tbl_sel_e'(cfg_sel) == rd_sel) && (cfg_addr[AW-1:0] == rd_idx)) begin
      rd_mask = cfg_data;
    end
  end

  // Tables are configuration state: written even during reset, never cleared
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      if (tbl_sel_e'(cfg_sel) == TBL_MCAST) begin
        mcast_tbl[cfg_addr[AW-1:0]] <= cfg_data;
      end else begin
        route_tbl[cfg_addr[AW-1:0]] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid           <= 1'b0;
      dp_valid           <= 1'b0;
      pending            <= '0;
      drop_cnt           <= '0;
      out_data           <= '0;
      out_pipeline_stall <= '1;
    end else begin
      if (fifo_pop) begin
        lk_valid <= 1'b1;
        pkt_lk   <= fifo_dout;
        mask_lk  <= rd_mask;
      end else if (lk_adv) begin
        lk_valid <= 1'b0;
      end

      // Zero-mask packets never occupy DP, so the next lookup follows without a bubble
      if (lk_adv) begin
        dp_valid <= (mask_lk != '0);
        pkt_dp   <= pkt_lk;
        pending  <= mask_lk;
        if (mask_lk == '0) begin
          drop_cnt <= sat_inc16(drop_cnt);
        end
      end else if (dp_valid) begin
        dp_valid <= ~dp_done;
        pending  <= pending & ~grant;
      end

      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_data[p*DataWidth +: DataWidth] <= grant[p] ? pkt_dp : '0;
      end
      out_pipeline_stall <= ~grant;
    end
  end

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: directed scenarios plus a randomized run
// checked against per-port delivery queues.
module tb_demux_dispatch;
  import demux_dispatch_pkg::*;

  localparam int DW = 256;
  localparam int MB = 253;
  localparam int IP = 186;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        in_pkt;
  logic                 in_pipeline_stall;
  logic                 in_avail;
  logic [7*DW-1:0]      out_data;
  logic [6:0]           out_pipeline_stall;
  logic [6:0]           out_avail;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [7:0]           cfg_addr;
  logic [6:0]           cfg_data;
  logic [15:0]          drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] portq [7][$];
  logic [6:0]    m_route [16];
  logic [6:0]    m_mcast [16];

  demux_dispatch #(
    .DataWidth              (DW),
    .MulticastBitPos        (MB),
    .DstPacketIDPos         (IP),
    .InterSwitchBufferDepth (4),
    .TableSize              (256)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in                 (in_pkt),
    .in_pipeline_stall  (in_pipeline_stall),
    .in_avail           (in_avail),
    .out_data           (out_data),
    .out_pipeline_stall (out_pipeline_stall),
    .out_avail          (out_avail),
    .cfg_we             (cfg_we),
    .cfg_sel            (cfg_sel),
    .cfg_addr           (cfg_addr),
    .cfg_data           (cfg_data),
    .drop_cnt           (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] make_pkt(input logic [7:0] idx, input logic mc);
    logic [DW-1:0] p;
    for (int i = 0; i < DW/32; i++) p[i*32 +: 32] = $urandom;
    p[DW-1]     = 1'b1;
    p[MB]       = mc;
    p[IP +: 8]  = idx;
    return p;
  endfunction

  function automatic logic [DW-1:0] slice(input int p);
    return out_data[p*DW +: DW];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [6:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_pipeline_stall = 1'b1; in_pkt = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL reset_stall got=%h exp=7f", out_pipeline_stall); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got nonzero exp=0"); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (in_avail !== 1'b1) begin failures++; $display("FAIL reset_in_avail got=%b exp=1", in_avail); end
  endtask

  task automatic test_unicast();
    logic [DW-1:0] p;
    reset_dut(); out_avail = 7'h7F;
    cfg_write(1'b0, 8'd5, 7'b0001000);
    p = make_pkt(8'd5, 1'b0);
    in_pkt = p; in_pipeline_stall = 1'b0; tick();
    in_pipeline_stall = 1'b1; tick(); tick();
    checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL uni_early got=%b exp=1111111", out_pipeline_stall); end
    tick();
    checks++; if (out_pipeline_stall !== 7'b1110111) begin failures++; $display("FAIL uni_stall got=%b exp=1110111", out_pipeline_stall); end
    checks++; if (slice(XPOS) !== p) begin failures++; $display("FAIL uni_data got=%h exp=%h", slice(XPOS), p); end
    tick();
    checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL uni_once got=%b exp=1111111", out_pipeline_stall); end
  endtask

  task automatic test_multicast_backpressure();
    logic [DW-1:0] a, b;
    reset_dut(); out_avail = 7'b0000010;
    cfg_write(1'b1, 8'd9, 7'b1000110);
    cfg_write(1'b0, 8'd5, 7'b0001000);
    a = make_pkt(8'd9, 1'b1); b = make_pkt(8'd5, 1'b0);
    in_pkt = a; in_pipeline_stall = 1'b0; tick();
    in_pkt = b; tick();
    in_pipeline_stall = 1'b1; tick(); tick();
    checks++; if (out_pipeline_stall !== 7'b1111101) begin failures++; $display("FAIL mc_first got=%b exp=1111101", out_pipeline_stall); end
    checks++; if (slice(YNEG) !== a) begin failures++; $display("FAIL mc_first_data got=%h exp=%h", slice(YNEG), a); end
    out_avail = 7'b0001010;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL mc_hold got=%b exp=1111111", out_pipeline_stall); end
    end
    out_avail = 7'h7F; tick();
    checks++; if (out_pipeline_stall !== 7'b0111011) begin failures++; $display("FAIL mc_rest got=%b exp=0111011", out_pipeline_stall); end
    checks++; if (slice(YPOS) !== a || slice(ZNEG) !== a) begin failures++; $display("FAIL mc_rest_data got=%h/%h exp=%h", slice(YPOS), slice(ZNEG), a); end
    tick();
    checks++; if (out_pipeline_stall !== 7'b1110111) begin failures++; $display("FAIL mc_next got=%b exp=1110111", out_pipeline_stall); end
    checks++; if (slice(XPOS) !== b) begin failures++; $display("FAIL mc_next_data got=%h exp=%h", slice(XPOS), b); end
    tick();
    checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL mc_no_resend got=%b exp=1111111", out_pipeline_stall); end
  endtask

  task automatic test_zero_mask();
    logic [DW-1:0] c, d;
    reset_dut(); out_avail = 7'h7F;
    cfg_write(1'b0, 8'd7, 7'b0000000);
    cfg_write(1'b0, 8'd5, 7'b0001000);
    c = make_pkt(8'd7, 1'b0); d = make_pkt(8'd5, 1'b0);
    in_pkt = c; in_pipeline_stall = 1'b0; tick();
    in_pkt = d; tick();
    in_pipeline_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL zm_silent got=%b exp=1111111", out_pipeline_stall); end
      tick();
    end
    checks++; if (out_pipeline_stall !== 7'b1110111) begin failures++; $display("FAIL zm_next got=%b exp=1110111", out_pipeline_stall); end
    checks++; if (slice(XPOS) !== d) begin failures++; $display("FAIL zm_next_data got=%h exp=%h", slice(XPOS), d); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL zm_drop got=%0d exp=1", drop_cnt); end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] pk [7];
    int got;
    reset_dut(); out_avail = 7'h00;
    cfg_write(1'b0, 8'd5, 7'b0001000);
    for (int k = 0; k < 7; k++) begin
      pk[k] = make_pkt(8'd5, 1'b0);
      checks++; if (in_avail !== (k < 6)) begin failures++; $display("FAIL full_in_avail push=%0d got=%b exp=%b", k, in_avail, (k < 6)); end
      in_pkt = pk[k]; in_pipeline_stall = 1'b0; tick();
    end
    in_pipeline_stall = 1'b1; out_avail = 7'h7F;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_pipeline_stall[XPOS] == 1'b0) begin
        checks++;
        if (got >= 6) begin failures++; $display("FAIL full_extra got=%0d exp=6", got + 1); end
        else if (slice(XPOS) !== pk[got]) begin failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", got, slice(XPOS), pk[got]); end
        got++;
      end
    end
    checks++; if (got != 6) begin failures++; $display("FAIL full_count got=%0d exp=6", got); end
    checks++; if (in_avail !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", in_avail); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] p;
    reset_dut(); out_avail = 7'h7F;
    cfg_write(1'b0, 8'd3, 7'b0100000);
    p = make_pkt(8'd3, 1'b0);
    in_pkt = p; in_pipeline_stall = 1'b0; tick();
    in_pipeline_stall = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd3; cfg_data = 7'b0000001; tick();
    cfg_we = 1'b0; tick(); tick();
    checks++; if (out_pipeline_stall !== 7'b1111110) begin failures++; $display("FAIL bypass_stall got=%b exp=1111110", out_pipeline_stall); end
    checks++; if (slice(LOCAL) !== p) begin failures++; $display("FAIL bypass_data got=%h exp=%h", slice(LOCAL), p); end
  endtask

  task automatic test_reset_mid_multicast();
    logic [DW-1:0] a, q;
    reset_dut(); out_avail = 7'b0000010;
    cfg_write(1'b1, 8'd9, 7'b1000110);
    cfg_write(1'b0, 8'd10, 7'b0100000);
    a = make_pkt(8'd9, 1'b1);
    in_pkt = a; in_pipeline_stall = 1'b0; tick();
    in_pipeline_stall = 1'b1; tick(); tick(); tick();
    checks++; if (out_pipeline_stall !== 7'b1111101) begin failures++; $display("FAIL rmc_partial got=%b exp=1111101", out_pipeline_stall); end
    rst = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd10; cfg_data = 7'b0000100; tick();
    checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL rmc_stall got=%b exp=1111111", out_pipeline_stall); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rmc_data got nonzero exp=0"); end
    rst = 1'b0; cfg_we = 1'b0; out_avail = 7'h7F;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_pipeline_stall !== 7'h7F) begin failures++; $display("FAIL rmc_resend got=%b exp=1111111", out_pipeline_stall); end
    end
    q = make_pkt(8'd10, 1'b0);
    in_pkt = q; in_pipeline_stall = 1'b0; tick();
    in_pipeline_stall = 1'b1; tick(); tick(); tick();
    checks++; if (out_pipeline_stall !== 7'b1111011) begin failures++; $display("FAIL rmc_cfg_in_reset got=%b exp=1111011", out_pipeline_stall); end
    checks++; if (slice(YPOS) !== q) begin failures++; $display("FAIL rmc_cfg_data got=%h exp=%h", slice(YPOS), q); end
  endtask

  task automatic test_random();
    logic [DW-1:0] p, e;
    logic [6:0]    m, prev_avail;
    logic [7:0]    idx;
    logic          v, st, mc;
    int            exp_drop;
    reset_dut(); out_avail = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      m_route[i] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      m_mcast[i] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      cfg_write(1'b0, 8'(i), m_route[i]);
      cfg_write(1'b1, 8'(i), m_mcast[i]);
    end
    for (int q = 0; q < 7; q++) portq[q].delete();
    exp_drop = 0; prev_avail = 7'h7F;
    for (int cyc = 0; cyc < 700; cyc++) begin
      for (int q = 0; q < 7; q++) begin
        if (out_pipeline_stall[q] == 1'b0) begin
          checks++; if (!prev_avail[q]) begin failures++; $display("FAIL rand_avail port=%0d got=offered exp=held", q); end
          checks++;
          if (portq[q].size() == 0) begin failures++; $display("FAIL rand_extra port=%0d got=%h exp=none", q, slice(q)); end
          else begin
            e = portq[q].pop_front();
            if (slice(q) !== e) begin failures++; $display("FAIL rand_data port=%0d got=%h exp=%h", q, slice(q), e); end
          end
        end else begin
          checks++; if (slice(q) !== '0) begin failures++; $display("FAIL rand_idle_data port=%0d got=%h exp=0", q, slice(q)); end
        end
      end
      if (cyc < 600) begin
        v = ($urandom_range(0, 9) != 0); st = ($urandom_range(0, 3) == 0);
        idx = 8'($urandom_range(0, 15)); mc = 1'($urandom_range(0, 1));
        p = make_pkt(idx, mc); p[DW-1] = v;
        if (v && !st && in_avail) begin
          m = mc ? m_mcast[idx[3:0]] : m_route[idx[3:0]];
          if (m == 7'd0) exp_drop++;
          for (int q = 0; q < 7; q++) if (m[q]) portq[q].push_back(p);
        end
        in_pkt = p; in_pipeline_stall = st;
        out_avail = 7'($urandom_range(0, 127)) | 7'($urandom_range(0, 127));
      end else begin
        in_pipeline_stall = 1'b1; out_avail = 7'h7F;
      end
      prev_avail = out_avail;
      tick();
    end
    for (int q = 0; q < 7; q++) begin
      checks++; if (portq[q].size() != 0) begin failures++; $display("FAIL rand_undelivered port=%0d got=%0d exp=0", q, portq[q].size()); end
    end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL rand_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
  endtask

  initial begin
    rst = 1'b1; in_pkt = '0; in_pipeline_stall = 1'b1; out_avail = 7'h7F;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    tick();
    test_reset();
    test_unicast();
    test_multicast_backpressure();
    test_zero_mask();
    test_fifo_full();
    test_bypass();
    test_reset_mid_multicast();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 SHALL have parameter DataWidth, default 256, packet width; bit DataWidth-1 is the valid flag.
REQ-002 SHALL have parameter MulticastBitPos, default 253, which is the packet bit selecting the multicast table.
REQ-003 SHALL have parameter DstPacketIDPos, default 186, the LSB of the 8-bit table index field.
REQ-004 SHALL have parameter InterSwitchBufferDepth, default 4, the input FIFO depth.
REQ-005 SHALL have parameter TableSize, default 256, the entries per table.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-008 SHALL have port in, input, DataWidth, the incoming link packet.
REQ-009 SHALL have port in_pipeline_stall, input, 1, where high means `in` is not offered.
REQ-010 SHALL have port in_avail, output, 1, which is the negation of input FIFO full.
REQ-011 SHALL have port out_data, output, 7*DataWidth, the per-port packet, with slice p = port p.
- Port order: 0 local, 1 yneg, 2 ypos, 3 xpos, 4 xneg, 5 zpos, 6 zneg.
REQ-012 SHALL have port out_pipeline_stall, output, 7, where high means slice p is not offered to the downstream mux.
REQ-013 SHALL have port out_avail, input, 7, the downstream mux FIFO-not-full for each port.
REQ-014 SHALL have table write ports cfg_we (input, 1), cfg_sel (input, 1; 0 = routing, 1 = multicast), cfg_addr (input, 8) and cfg_data (input, 7; port mask).
REQ-015 SHALL have port drop_cnt, output, 16, the count of dropped packets.

Function
REQ-016 SHALL push `in` into the FIFO when in_pipeline_stall is 0 and in[DataWidth-1] is 1; a push while the FIFO is full is ignored.
REQ-017 SHALL have an LK stage: when the FIFO is non-empty and LK is empty or advancing, pop the head, register the packet, and read the mask synchronously.
- Index = pkt[DstPacketIDPos+7:DstPacketIDPos].
- Multicast table if pkt[MulticastBitPos] = 1, otherwise routing table; reduction packets use the routing table.
REQ-018 SHALL, when cfg_we writes the same table and address being read in the same cycle, return cfg_data to LK (write-first bypass).
REQ-019 SHALL advance LK into the DP stage (pkt_dp, pending <= mask) when DP is empty or completes in that cycle; back-to-back transfer carries no bubble.
REQ-020 SHALL, in DP each cycle, compute grant = pending & out_avail, register the outputs and set pending <= pending & ~grant.
- Registered outputs: for grant[p], slice p = pkt_dp and out_pipeline_stall[p] = 0; otherwise slice p = 0 and out_pipeline_stall[p] = 1.
REQ-021 SHALL treat DP as complete when pending & ~grant == 0; partial multicast delivery is allowed, and no port receives the same packet twice.
REQ-022 SHALL drop a packet entering DP with a zero mask without driving any output, and increment drop_cnt, which saturates at 16'hFFFF.
REQ-023 SHALL give a minimum latency from push to out_data of 4 cycles: FIFO write, FIFO pop/LK, DP, output register.
REQ-024 SHALL stall LK, with no pop, while DP is incomplete and LK is full; FIFO order is preserved end to end.
REQ-025 SHALL keep in_avail = ~FIFO_full combinationally.

Reset
REQ-026 SHALL, while rst is high at a clock edge, do all of the following:
- clear the FIFO, the LK and DP valid flags, and pending;
- drive out_data to 0 and out_pipeline_stall to 7'h7F;
- set drop_cnt to 0.
REQ-027 SHALL discard any in-flight or partially delivered packet on reset mid-operation; tables are not reset and keep their contents.
REQ-028 SHALL still perform table writes while rst is high.

Structure
REQ-029 SHALL place port index constants (LOCAL..ZNEG) and field position defaults in the shared network package.
REQ-030 SHALL instantiate the existing FIFO module (FIFO_depth = InterSwitchBufferDepth, FIFO_width = DataWidth) as its only sub-module.

Verification
REQ-031 SHALL cover a unicast: route[5] = 7'b0001000, a packet with index 5 and out_avail = 7'h7F -> slice 3 carries the packet 4 cycles later, and all other stalls are 1.
REQ-032 SHALL cover multicast with backpressure: mcast[9] = 7'b1000110 and out_avail = 7'b0000010 -> port 1 gets it first; raising the remaining bits -> ports 2 and 6 receive it once each, and the next packet is held until then.
REQ-033 SHALL cover a zero mask: route[7] = 0 and a packet with index 7 -> no output, drop_cnt = 1, and the following packet is unaffected.
REQ-034 SHALL cover FIFO full: out_avail = 0 and 7 packets pushed -> in_avail falls after 6 accepted (4 FIFO + LK + DP), and the 7th push is ignored.
REQ-035 SHALL cover the write/read bypass: a cfg write to route[3] = 7'b0000001 in the same cycle LK reads index 3 -> the packet goes to port 0.
REQ-036 SHALL cover reset mid-multicast: assert rst with pending = 7'b1000100 -> the next cycle shows stalls = 7'h7F, out_data = 0 and no resend.
